id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated hazard control for the 5-stage MIPS core. It captures the decoder's control bundle plus operands at the ID→EX boundary and detects load-use hazards. On a load-use hazard it stalls IF/ID and inserts a bubble. On a taken branch (resolved in EX) or a jump (decoded in ID) it requests flushes. It also keeps stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_Branch`, `id_ALUSrc1`, `id_ALUSrc2`  in  1 each  control bits from the decoder.
- `id_RegDst`, `id_MemtoReg`, `id_PCSrc`  in  2 each  control fields from the decoder.
- `id_ALUOp`  in  4  ALU operation class.
- `id_pc_plus4`, `id_rs_data`, `id_rt_data`, `id_imm_ext`  in  32 each  ID-stage operands.
- `id_rs`, `id_rt`, `id_rd`, `id_shamt`  in  5 each  register specifiers and shift amount.
- `id_funct`  in  6  instruction funct field.
- `ex_branch_taken`  in  1  EX-stage branch outcome: ex_Branch AND ALU zero, same cycle.
- `ex_*`  out  (same widths as id_*, PCSrc excluded)  registered copies of every id_* input above except PCSrc.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `flush_ifid`  out  1  squash IF/ID on the next edge.
- `stall_count`, `flush_count`  out  CNT_W each  performance counters.

## Operation
- **Load-use hazard.** `lu_hazard = ex_MemRead & ex_RegWrite & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`. A load always writes rt.
- **stall** = `lu_hazard & ~ex_branch_taken`.
- **flush_ifid** = `ex_branch_taken | ((id_PCSrc != 2'b00) & ~stall)`.
- **Bubble:** every ex_* output, control and data, loads 0. This makes the bubble equal to `sll $0,$0,0` with RegWrite=0.
- **Next-state priority, highest first:**
  1. `reset`: all ex_* = 0 and both counters = 0.
  2. `ex_branch_taken`: load a bubble; the ID instruction is on the wrong path.
  3. `stall`: load a bubble; ID holds, so the same instruction is re-presented next cycle.
  4. Otherwise: load the id_* values.
- **Jumps.** A jump (j, jal, jr, jalr) in ID passes into ID/EX normally, so jal and jalr still write back. Only the fetched successor is flushed.
- **jr/jalr behind a load.** If the load's target is rs, the stall takes precedence and the flush is deferred one cycle.
- **stall_count** increments on every non-reset cycle with `stall=1`.
- **flush_count** increments on every non-reset cycle with `flush_ifid=1`.
- Both counters wrap modulo 2^CNT_W.
- No internal FSM beyond the register. The stall lasts exactly one cycle by construction: after the bubble, ex_MemRead=0.

## Timing
- Latency: id_* to ex_* is 1 cycle.
- `stall` and `flush_ifid` are combinational from the current id_* inputs, the registered ex_* values, and `ex_branch_taken`. They are valid in the same cycle, before the edge.
- Reset values: every ex_* = 0, `stall_count` = `flush_count` = 0.
  - `stall` and `flush_ifid` evaluate to 0 once the ex_* registers are cleared, provided `ex_branch_taken` and `id_PCSrc` are 0.
- Reset asserted mid-stall or mid-flush: the register clears on that edge; the counters do not increment on that cycle.
- Simultaneous load-use and taken branch: bubble, `stall=0`, `flush_ifid=1`, and only `flush_count` increments.
- Specifier 0 never triggers a hazard.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random id_* → all ex_* = 0, counters = 0, `stall=0`.
- **Pass-through:** id_* = `add $3,$1,$2` fields with id_rs_data=5 and id_rt_data=7, no hazards → next cycle ex_rs_data=5, ex_rt_data=7, ex_RegWrite=1, ex_ALUOp=4'b0010.
- **Load-use:** `lw $4,0($1)` then `add $5,$4,$2` → `stall=1` for exactly 1 cycle and one bubble in ex_*. The add appears in ex_* one cycle later, and `stall_count` = 1.
- **Zero register:** `lw $0,...` followed by a use of `$0` → `stall` stays 0.
- **Branch flush:** beq in EX with `ex_branch_taken=1` while ID holds a load-use consumer → bubble, `flush_ifid=1`, `stall=0`, `flush_count` +1, `stall_count` unchanged.
- **jal:** id_PCSrc=2'b01, id_RegDst=2'b10 → `flush_ifid=1` the same cycle, and next cycle ex_RegDst=2'b10 with ex_RegWrite=1 (not bubbled).

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard
// detection, branch/jump flush requests and stall/flush performance counters.
module id_ex_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic             id_ALUSrc1,
    input  logic             id_ALUSrc2,
    input  logic [1:0]       id_RegDst,
    input  logic [1:0]       id_MemtoReg,
    input  logic [1:0]       id_PCSrc,
    input  logic [3:0]       id_ALUOp,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm_ext,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    input  logic [5:0]       id_funct,
    input  logic             ex_branch_taken,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_Branch,
    output logic             ex_ALUSrc1,
    output logic             ex_ALUSrc2,
    output logic [1:0]       ex_RegDst,
    output logic [1:0]       ex_MemtoReg,
    output logic [3:0]       ex_ALUOp,
    output logic [31:0]      ex_pc_plus4,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm_ext,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [5:0]       ex_funct,
    output logic             stall,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic luHazard;
    logic loadBubble;

    // A load in EX writes rt; any ID reader of that rt must wait one cycle.
    // Register 0 is never a real dependency.
    assign luHazard = ex_MemRead & ex_RegWrite & (ex_rt != 5'd0)
                    & ((ex_rt == id_rs) | (ex_rt == id_rt));

    // A taken branch squashes the ID instruction anyway, so it overrides the stall.
    assign stall = luHazard & ~ex_branch_taken;

    // Jumps flush only their fetched successor; when stalled the jump is
    // re-presented next cycle and flushes then.
    assign flush_ifid = ex_branch_taken | ((id_PCSrc != 2'b00) & ~stall);

    assign loadBubble = ex_branch_taken | stall;

    // ID/EX register: a bubble is all zeros (sll $0,$0,0 with no writeback)
    always_ff @(posedge clk) begin
        if (reset || loadBubble) begin
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUSrc1  <= 1'b0;
            ex_ALUSrc2  <= 1'b0;
            ex_RegDst   <= 2'b00;
            ex_MemtoReg <= 2'b00;
            ex_ALUOp    <= 4'd0;
            ex_pc_plus4 <= 32'd0;
            ex_rs_data  <= 32'd0;
            ex_rt_data  <= 32'd0;
            ex_imm_ext  <= 32'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_shamt    <= 5'd0;
            ex_funct    <= 6'd0;
        end else begin
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_ALUSrc1  <= id_ALUSrc1;
            ex_ALUSrc2  <= id_ALUSrc2;
            ex_RegDst   <= id_RegDst;
            ex_MemtoReg <= id_MemtoReg;
            ex_ALUOp    <= id_ALUOp;
            ex_pc_plus4 <= id_pc_plus4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm_ext  <= id_imm_ext;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_shamt    <= id_shamt;
            ex_funct    <= id_funct;
        end
    end

    // Performance counters: wrap naturally, never count a reset cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall)      stall_count <= stall_count + CNT_W'(1);
            if (flush_ifid) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
